// File: rtl/dff_bist_if.sv
// Bus between the dff BIST checker and its controller/DUT side.
// The master drives start and returns the DUT's Q; the slave is the checker itself.
interface dff_bist_if #(
  parameter int IDX_W = 8
);
  logic             start;
  logic             dut_d;
  logic             dut_rst_n;
  logic             dut_q;
  logic             busy;
  logic             done;
  logic             pass;
  logic [IDX_W-1:0] err_cnt;
  logic [IDX_W-1:0] first_err_idx;

  modport master (
    output start, dut_q,
    input  dut_d, dut_rst_n, busy, done, pass, err_cnt, first_err_idx
  );

  modport slave (
    input  start, dut_q,
    output dut_d, dut_rst_n, busy, done, pass, err_cnt, first_err_idx
  );
endinterface

// File: rtl/dff_bist_checker.sv
// On-chip stimulus/response engine for a single-bit register DUT: drives LFSR-random
// D/rst_n, models the expected Q, and reports an error count and first failing vector.
module dff_bist_checker #(
  parameter int          NUM_VEC = 100,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          IDX_W   = 8
) (
  input logic       clk,
  input logic       rst,
  dff_bist_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting towards bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [IDX_W-1:0] vec_idx_q, vec_idx_d;
  logic             dut_d_q, dut_d_d;
  logic             dut_rst_n_q, dut_rst_n_d;
  logic             exp_q, exp_d;
  logic             exp_vld_q, exp_vld_d;
  logic [IDX_W-1:0] exp_idx_q, exp_idx_d;
  logic [IDX_W-1:0] err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0] first_err_q, first_err_d;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    vec_idx_d   = vec_idx_q;
    dut_d_d     = 1'b0;
    dut_rst_n_d = 1'b1;
    exp_d       = exp_q;
    exp_vld_d   = 1'b0;
    exp_idx_d   = exp_idx_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;

    // Compare stage: exp_q holds the Q expected during this cycle.
    if (exp_vld_q && (bus.dut_q != exp_q)) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      if (err_cnt_q == '0) first_err_d = exp_idx_q;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = RUN;
          lfsr_d      = lfsr_step(SEED);
          vec_idx_d   = '0;
          dut_d_d     = SEED[0];
          dut_rst_n_d = SEED[1];
          err_cnt_d   = '0;
          first_err_d = '0;
        end
      end
      RUN: begin
        exp_d     = dut_rst_n_q & dut_d_q;
        exp_vld_d = 1'b1;
        exp_idx_d = vec_idx_q;
        if (vec_idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          dut_d_d     = lfsr_q[0];
          dut_rst_n_d = lfsr_q[1];
          lfsr_d      = lfsr_step(lfsr_q);
          vec_idx_d   = vec_idx_q + 1'b1;
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments; rst clears it asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      vec_idx_q   <= '0;
      dut_d_q     <= 1'b0;
      dut_rst_n_q <= 1'b1;
      exp_q       <= 1'b0;
      exp_vld_q   <= 1'b0;
      exp_idx_q   <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      vec_idx_q   <= vec_idx_d;
      dut_d_q     <= dut_d_d;
      dut_rst_n_q <= dut_rst_n_d;
      exp_q       <= exp_d;
      exp_vld_q   <= exp_vld_d;
      exp_idx_q   <= exp_idx_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  assign bus.dut_d         = dut_d_q;
  assign bus.dut_rst_n     = dut_rst_n_q;
  assign bus.busy          = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done          = (state_q == DONE);
  assign bus.pass          = (state_q == DONE) && (err_cnt_q == '0);
  assign bus.err_cnt       = err_cnt_q;
  assign bus.first_err_idx = first_err_q;

endmodule

// File: tb/tb_dff_bist_checker.sv
// Bench for dff_bist_checker: bench-side DUT models, a golden vector/result model,
// and a scoreboard monitor comparing vector streams and end-of-run reports.
module tb_dff_bist_checker;

  localparam int N0 = 100;
  localparam int N1 = 1;
  localparam logic [15:0] SEED0 = 16'hACE1;
  localparam logic [15:0] SEED1 = 16'hBEEF;

  typedef enum int {M_IDEAL, M_STUCK1, M_STUCK0, M_DELAY} mode_e;
  typedef struct packed {logic d; logic rn;} vec_t;
  typedef struct {int err; int first;} res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dff_bist_if #(.IDX_W(8)) bus0 ();
  dff_bist_if #(.IDX_W(2)) bus1 ();

  dff_bist_checker #(.NUM_VEC(N0), .SEED(SEED0), .IDX_W(8)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  dff_bist_checker #(.NUM_VEC(N1), .SEED(SEED1), .IDX_W(2)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // Register under test: Q follows D at the clock, cleared when rst_n is low at that edge.
  mode_e mode = M_IDEAL;
  logic  ref_q = 1'b0;
  logic  dly_q = 1'b0;
  always @(posedge clk) begin
    ref_q <= bus0.dut_rst_n ? bus0.dut_d : 1'b0;
    dly_q <= ref_q;
  end
  assign bus0.dut_q = (mode == M_IDEAL)  ? ref_q :
                      (mode == M_DELAY)  ? dly_q :
                      (mode == M_STUCK1) ? 1'b1  : 1'b0;
  assign bus1.dut_q = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Golden model: vector list from the LFSR polynomial, result from the compare rules.
  vec_t gold [256];

  function automatic void build_gold(input int unsigned seed, input int n);
    int unsigned s, fb;
    s = seed & 32'hFFFF;
    for (int k = 0; k < n; k++) begin
      gold[k].d  = (s & 1) != 0;
      gold[k].rn = ((s >> 1) & 1) != 0;
      fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
      s  = (s >> 1) | (fb << 15);
    end
  endfunction

  function automatic res_t predict(input int n, input mode_e m, input int sat);
    res_t r;
    int   e, got, prev;
    r.err = 0; r.first = 0; prev = 0;
    for (int k = 0; k < n; k++) begin
      e = (gold[k].rn && gold[k].d) ? 1 : 0;
      case (m)
        M_IDEAL:  got = e;
        M_STUCK1: got = 1;
        M_STUCK0: got = 0;
        default:  got = prev;
      endcase
      if (got != e) begin
        if (r.err == 0) r.first = k;
        if (r.err < sat) r.err++;
      end
      prev = e;
    end
    return r;
  endfunction

  vec_t vec_q [$];
  res_t res_q [$];

  // Monitor: per busy cycle compare the driven vector; when busy drops, compare the report.
  int   mon_c = 0;
  logic busy_prev = 1'b0;
  initial begin
    vec_t v;
    res_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_c = 0;
        busy_prev = 1'b0;
      end else begin
        if (bus0.busy === 1'b1) begin
          if (mon_c < N0) begin
            if (vec_q.size() > 0) begin
              v = vec_q.pop_front();
              check("vector", {30'd0, bus0.dut_d, bus0.dut_rst_n}, {30'd0, v.d, v.rn});
            end else begin
              check("vector_queue_empty", 32'd1, 32'd0);
            end
          end
          if (mon_c == 0 || mon_c == N0) check("pass_low_while_busy", {31'd0, bus0.pass}, 32'd0);
          mon_c++;
        end else if (busy_prev) begin
          check("busy_length", mon_c, N0 + 1);
          check("done_after_busy", {31'd0, bus0.done}, 32'd1);
          if (res_q.size() > 0) begin
            r = res_q.pop_front();
            check("err_cnt", {24'd0, bus0.err_cnt}, r.err);
            if (r.err != 0) check("first_err_idx", {24'd0, bus0.first_err_idx}, r.first);
            check("pass", {31'd0, bus0.pass}, (r.err == 0) ? 32'd1 : 32'd0);
          end else begin
            check("result_queue_empty", 32'd1, 32'd0);
          end
          mon_c = 0;
        end
        busy_prev = bus0.busy;
      end
    end
  end

  task automatic push_run(input mode_e m);
    build_gold(SEED0, N0);
    for (int k = 0; k < N0; k++) vec_q.push_back(gold[k]);
    res_q.push_back(predict(N0, m, 255));
  endtask

  // Called at posedge+1; returns at posedge+1 of the first DONE cycle.
  task automatic run(input mode_e m, input bit spam, input int gap);
    int cycles;
    bit seen;
    repeat (gap) begin @(posedge clk); #1; end
    mode = m;
    push_run(m);
    bus0.start = 1'b1;
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      seen = (bus0.done === 1'b1);
      bus0.start = spam && (bus0.busy === 1'b1) && ($urandom_range(3) == 0);
    end
    bus0.start = 1'b0;
    if (!seen) check("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dut_d"},     {31'd0, bus0.dut_d},     32'd0);
    check({tag, "_dut_rst_n"}, {31'd0, bus0.dut_rst_n}, 32'd1);
    check({tag, "_busy"},      {31'd0, bus0.busy},      32'd0);
    check({tag, "_done"},      {31'd0, bus0.done},      32'd0);
    check({tag, "_pass"},      {31'd0, bus0.pass},      32'd0);
    check({tag, "_err_cnt"},   {24'd0, bus0.err_cnt},   32'd0);
    check({tag, "_first_idx"}, {24'd0, bus0.first_err_idx}, 32'd0);
  endtask

  initial begin
    res_t r1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;

    #3 rst = 1'b1;
    #1 check_reset_state("reset");
    #13 rst = 1'b0;
    @(posedge clk); #1;

    run(M_IDEAL,  1'b0, 2);
    run(M_STUCK1, 1'b1, 3);
    run(M_DELAY,  1'b0, 2);
    run(M_STUCK0, 1'b1, 1);

    // Abort at vector 50: outputs clear asynchronously, no report is produced.
    repeat (2) begin @(posedge clk); #1; end
    mode = M_STUCK1;
    push_run(M_STUCK1);
    bus0.start = 1'b1;
    @(posedge clk); #1 bus0.start = 1'b0;
    repeat (50) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_state("abort");
    vec_q.delete();
    res_q.delete();
    @(posedge clk); #1 rst = 1'b0;

    // Fresh start after abort, then back-to-back reruns started from DONE.
    run(M_IDEAL,  1'b1, 2);
    run(M_STUCK1, 1'b0, 0);
    run(M_STUCK1, 1'b1, 0);

    for (int i = 0; i < 3; i++) begin
      run(mode_e'($urandom_range(3)), 1'(($urandom_range(1))), int'($urandom_range(4)));
    end

    repeat (3) begin @(posedge clk); #1; end
    check("results_outstanding", res_q.size(), 0);
    check("vectors_outstanding", vec_q.size(), 0);

    // Single-vector instance with a stuck-at-0 register.
    build_gold(SEED1, N1);
    r1 = predict(N1, M_STUCK0, 3);
    bus1.start = 1'b1;
    @(posedge clk); #1 bus1.start = 1'b0;
    check("n1_busy_c0",  {31'd0, bus1.busy},      32'd1);
    check("n1_vec0",     {30'd0, bus1.dut_d, bus1.dut_rst_n}, {30'd0, gold[0].d, gold[0].rn});
    @(posedge clk); #1;
    check("n1_busy_c1",  {31'd0, bus1.busy},      32'd1);
    check("n1_done_c1",  {31'd0, bus1.done},      32'd0);
    @(posedge clk); #1;
    check("n1_done",     {31'd0, bus1.done},      32'd1);
    check("n1_busy_end", {31'd0, bus1.busy},      32'd0);
    check("n1_err_cnt",  {30'd0, bus1.err_cnt},   r1.err);
    check("n1_first",    {30'd0, bus1.first_err_idx}, r1.first);
    check("n1_pass",     {31'd0, bus1.pass},      (r1.err == 0) ? 32'd1 : 32'd0);
    check("n1_dut_rst_n_idle", {31'd0, bus1.dut_rst_n}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
